// File: rtl/dev_input_fifo.sv
// Buffered input device: producer valid/ready push into a circular FIFO, CPU reads/pops via device registers.
// Optional irq_en register and level interrupt are built when DEV_INPUT_FIFO_IRQ_EN is defined.
module dev_input_fifo #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] dev_out,
  input  logic [31:0] dev_in,
  input  logic [7:0]  dev_addr,
  input  logic        we,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        in_ready,
  output logic        irq
);

  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

  logic [31:0]      mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W:0]   count;
  logic             overflow;
  logic             empty;
  logic             full;
  logic             push;
  logic             pop;
  logic             ctrl_wr;
  logic             ctrl_bit0;

  assign empty    = (count == '0);
  assign full     = (count == FULL_COUNT);
  assign in_ready = ~full;
  assign push     = in_valid && !full;
  assign pop      = we && (dev_addr == 8'h08) && !empty;
  assign ctrl_wr  = we && (dev_addr == 8'h0C);

  // Storage has no reset; only the write is suppressed while rst is low.
  always_ff @(posedge clk) begin
    if (rst && push) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      // A set in the same cycle as a clear takes priority.
      if (in_valid && full)         overflow <= 1'b1;
      else if (ctrl_wr && dev_in[1]) overflow <= 1'b0;
    end
  end

`ifdef DEV_INPUT_FIFO_IRQ_EN
  logic irq_en;

  always_ff @(posedge clk) begin
    if (!rst)         irq_en <= 1'b0;
    else if (ctrl_wr) irq_en <= dev_in[0];
  end

  assign irq       = irq_en && !empty;
  assign ctrl_bit0 = irq_en;

  logic unused_dev_in;
  assign unused_dev_in = ^dev_in[31:2];
`else
  assign irq       = 1'b0;
  assign ctrl_bit0 = 1'b0;

  logic unused_dev_in;
  assign unused_dev_in = ^{dev_in[31:2], dev_in[0]};
`endif

  always_comb begin
    dev_out = 32'hdead_beef;
    case (dev_addr)
      8'h00:   dev_out = empty ? '0 : mem[rd_ptr];
      8'h04:   dev_out = {16'h0, 8'(count), 5'h0, overflow, full, empty};
      8'h08:   dev_out = '0;
      8'h0C:   dev_out = {31'h0, ctrl_bit0};
      default: dev_out = 32'hdead_beef;
    endcase
  end

endmodule

// File: tb/tb_dev_input_fifo.sv
// Self-checking bench for dev_input_fifo: directed scenarios plus random traffic against a queue-based model.
module tb_dev_input_fifo;
  localparam int DEPTH = 8;
`ifdef DEV_INPUT_FIFO_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] dev_out;
  logic [31:0] dev_in = '0;
  logic [7:0]  dev_addr = '0;
  logic        we = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_ready;
  logic        irq;

  int total = 0;
  int bad = 0;

  logic [31:0] q[$];
  bit          m_ovf = 1'b0;
  bit          m_irqen = 1'b0;

  dev_input_fifo #(.DEPTH(DEPTH), .PTR_W(3)) dut (
    .clk(clk), .rst(rst), .dev_out(dev_out), .dev_in(dev_in), .dev_addr(dev_addr),
    .we(we), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready), .irq(irq)
  );

  always #5 clk = ~clk;

  // One clock edge with the given inputs; the model follows the same edge.
  task automatic step(input bit v, input logic [31:0] d, input bit w, input logic [7:0] a,
                      input logic [31:0] din, input bit r = 1'b1);
    bit fullm;
    bit popm;
    in_valid = v; in_data = d; we = w; dev_addr = a; dev_in = din; rst = r;
    @(posedge clk);
    if (!r) begin
      q.delete();
      m_ovf = 1'b0;
      m_irqen = 1'b0;
    end else begin
      fullm = (q.size() == DEPTH);
      popm  = w && (a == 8'h08) && (q.size() != 0);
      if (v && fullm) m_ovf = 1'b1;
      else if (w && a == 8'h0C && din[1]) m_ovf = 1'b0;
      if (w && a == 8'h0C && IRQ_ON) m_irqen = din[0];
      if (popm) void'(q.pop_front());
      if (v && !fullm) q.push_back(d);
    end
    #1;
    in_valid = 1'b0; we = 1'b0; rst = 1'b1;
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] v);
    dev_addr = a;
    #1;
    v = dev_out;
  endtask

  function automatic logic [31:0] exp_reg(input logic [7:0] a);
    logic [7:0] cnt;
    cnt = 8'(q.size());
    case (a)
      8'h00:   return (q.size() != 0) ? q[0] : 32'h0;
      8'h04:   return {16'h0, cnt, 5'h0, m_ovf, q.size() == DEPTH, q.size() == 0};
      8'h08:   return 32'h0;
      8'h0C:   return {31'h0, m_irqen};
      default: return 32'hdead_beef;
    endcase
  endfunction

  task automatic test_reset();
    logic [31:0] v;
    step(1'b0, 0, 1'b0, 0, 0, 1'b0);
    step(1'b0, 0, 1'b0, 0, 0, 1'b0);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b want=0", irq); end
    rd(8'h00, v);
    total++; if (v !== 32'h0) begin bad++; $display("FAIL reset_data got=%h want=0", v); end
    rd(8'h04, v);
    total++; if (v !== 32'h1) begin bad++; $display("FAIL reset_status got=%h want=1", v); end
  endtask

  task automatic test_basic();
    logic [31:0] v;
    step(1'b1, 32'h11, 1'b0, 0, 0);
    step(1'b1, 32'h22, 1'b0, 0, 0);
    step(1'b1, 32'h33, 1'b0, 0, 0);
    rd(8'h00, v);
    total++; if (v !== 32'h11) begin bad++; $display("FAIL basic_data got=%h want=11", v); end
    rd(8'h04, v);
    total++; if (v !== 32'h0000_0300) begin bad++; $display("FAIL basic_status got=%h want=300", v); end
    step(1'b0, 0, 1'b1, 8'h08, 0);
    step(1'b0, 0, 1'b1, 8'h08, 32'hffff_ffff);
    rd(8'h00, v);
    total++; if (v !== 32'h33) begin bad++; $display("FAIL basic_pop_data got=%h want=33", v); end
    rd(8'h04, v);
    total++; if (v !== 32'h0000_0100) begin bad++; $display("FAIL basic_pop_status got=%h want=100", v); end
    step(1'b0, 0, 1'b1, 8'h08, 0);
  endtask

  task automatic test_full_overflow();
    logic [31:0] v;
    for (int i = 1; i <= DEPTH; i++) step(1'b1, 32'(i), 1'b0, 0, 0);
    rd(8'h04, v);
    total++; if (v !== 32'h0000_0802) begin bad++; $display("FAIL full_status got=%h want=802", v); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL full_in_ready got=%b want=0", in_ready); end
    step(1'b1, 32'h9, 1'b0, 0, 0);
    rd(8'h04, v);
    total++; if (v !== 32'h0000_0806) begin bad++; $display("FAIL ovf_status got=%h want=806", v); end
    for (int i = 1; i <= DEPTH; i++) begin
      rd(8'h00, v);
      total++; if (v !== 32'(i)) begin bad++; $display("FAIL full_order[%0d] got=%h want=%h", i, v, 32'(i)); end
      step(1'b0, 0, 1'b1, 8'h08, 0);
    end
    rd(8'h04, v);
    total++; if (v !== 32'h0000_0005) begin bad++; $display("FAIL drained_status got=%h want=5", v); end
    step(1'b0, 0, 1'b1, 8'h0C, 32'h2);
    rd(8'h04, v);
    total++; if (v !== 32'h1) begin bad++; $display("FAIL ovf_clear got=%h want=1", v); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] v;
    for (int i = 0; i < 4; i++) step(1'b1, 32'hA0 + 32'(i), 1'b0, 0, 0);
    step(1'b1, 32'hA4, 1'b1, 8'h08, 0);
    rd(8'h04, v);
    total++; if (v !== 32'h0000_0400) begin bad++; $display("FAIL b2b_status got=%h want=400", v); end
    rd(8'h00, v);
    total++; if (v !== 32'hA1) begin bad++; $display("FAIL b2b_data got=%h want=a1", v); end
    for (int i = 0; i < 4; i++) step(1'b0, 0, 1'b1, 8'h08, 0);
    step(1'b1, 32'h55, 1'b1, 8'h08, 0);
    rd(8'h04, v);
    total++; if (v !== 32'h0000_0100) begin bad++; $display("FAIL empty_pp_status got=%h want=100", v); end
    rd(8'h00, v);
    total++; if (v !== 32'h55) begin bad++; $display("FAIL empty_pp_data got=%h want=55", v); end
    step(1'b0, 0, 1'b1, 8'h08, 0);
  endtask

  task automatic test_empty_pop();
    logic [31:0] v;
    step(1'b0, 0, 1'b1, 8'h08, 0);
    rd(8'h04, v);
    total++; if (v !== 32'h1) begin bad++; $display("FAIL empty_pop_status got=%h want=1", v); end
    rd(8'h20, v);
    total++; if (v !== 32'hdead_beef) begin bad++; $display("FAIL unmapped_20 got=%h want=deadbeef", v); end
    rd(8'h01, v);
    total++; if (v !== 32'hdead_beef) begin bad++; $display("FAIL unmapped_01 got=%h want=deadbeef", v); end
    rd(8'h08, v);
    total++; if (v !== 32'h0) begin bad++; $display("FAIL pop_reads got=%h want=0", v); end
    step(1'b0, 0, 1'b1, 8'h04, 32'hffff_ffff);
    step(1'b1, 32'h66, 1'b0, 0, 0);
    rd(8'h00, v);
    total++; if (v !== 32'h66) begin bad++; $display("FAIL empty_pop_ptr got=%h want=66", v); end
    step(1'b0, 0, 1'b1, 8'h08, 0);
  endtask

  task automatic test_irq();
    logic [31:0] v;
    step(1'b0, 0, 1'b1, 8'h0C, 32'h1);
    rd(8'h0C, v);
    total++; if (v !== {31'h0, IRQ_ON}) begin bad++; $display("FAIL ctrl_read got=%h want=%h", v, {31'h0, IRQ_ON}); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_idle got=%b want=0", irq); end
    step(1'b1, 32'hABCD, 1'b0, 0, 0);
    total++; if (irq !== IRQ_ON) begin bad++; $display("FAIL irq_push got=%b want=%b", irq, IRQ_ON); end
    step(1'b0, 0, 1'b1, 8'h08, 0);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_pop got=%b want=0", irq); end
    step(1'b0, 0, 1'b1, 8'h0C, 32'h0);
  endtask

  task automatic test_set_wins();
    logic [31:0] v;
    for (int i = 0; i < DEPTH; i++) step(1'b1, 32'hC0 + 32'(i), 1'b0, 0, 0);
    step(1'b1, 32'hF, 1'b1, 8'h0C, 32'h2);
    rd(8'h04, v);
    total++; if (v !== 32'h0000_0806) begin bad++; $display("FAIL set_wins got=%h want=806", v); end
    step(1'b0, 0, 1'b1, 8'h0C, 32'h2);
    rd(8'h04, v);
    total++; if (v !== 32'h0000_0802) begin bad++; $display("FAIL clear_full got=%h want=802", v); end
    for (int i = 0; i < DEPTH; i++) step(1'b0, 0, 1'b1, 8'h08, 0);
  endtask

  task automatic test_reset_mid();
    logic [31:0] v;
    for (int i = 0; i < 5; i++) step(1'b1, 32'hD0 + 32'(i), 1'b0, 0, 0);
    step(1'b1, 32'h99, 1'b1, 8'h08, 0, 1'b0);
    rd(8'h04, v);
    total++; if (v !== 32'h1) begin bad++; $display("FAIL rst_mid_status got=%h want=1", v); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_mid_in_ready got=%b want=1", in_ready); end
    rd(8'h00, v);
    total++; if (v !== 32'h0) begin bad++; $display("FAIL rst_mid_data got=%h want=0", v); end
    step(1'b1, 32'h77, 1'b0, 0, 0);
    rd(8'h00, v);
    total++; if (v !== 32'h77) begin bad++; $display("FAIL rst_mid_restart got=%h want=77", v); end
  endtask

  task automatic test_random();
    logic [31:0] v;
    logic [7:0]  addrs [5];
    logic [7:0]  a;
    addrs[0] = 8'h00; addrs[1] = 8'h04; addrs[2] = 8'h08; addrs[3] = 8'h0C; addrs[4] = 8'h10;
    for (int n = 0; n < 600; n++) begin
      a = ($urandom_range(0, 9) < 6) ? 8'h08 : addrs[$urandom_range(0, 4)];
      step($urandom_range(0, 9) < 5, $urandom, $urandom_range(0, 9) < 4, a, $urandom,
           $urandom_range(0, 99) != 0);
      for (int k = 0; k < 5; k++) begin
        rd(addrs[k], v);
        total++;
        if (v !== exp_reg(addrs[k])) begin
          bad++; $display("FAIL rand_reg[%0d] addr=%h got=%h want=%h", n, addrs[k], v, exp_reg(addrs[k]));
        end
      end
      total++;
      if (in_ready !== (q.size() != DEPTH)) begin
        bad++; $display("FAIL rand_in_ready[%0d] got=%b want=%b", n, in_ready, q.size() != DEPTH);
      end
      total++;
      if (irq !== (m_irqen && q.size() != 0)) begin
        bad++; $display("FAIL rand_irq[%0d] got=%b want=%b", n, irq, m_irqen && q.size() != 0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full_overflow();
    test_back_to_back();
    test_empty_pop();
    test_irq();
    test_set_wins();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
